// File: rtl/datapath_run_ctrl.sv
// Run/stop sequencer for the datapath core: start, stop, single-step, halt-cause reporting.
// Optional PC breakpoint and its skip flag are built only when RUN_CTRL_BREAKPOINT_EN is defined.
module datapath_run_ctrl #(
  parameter int unsigned PC_W       = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MAX_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  logic              stop,
  input  logic              bp_valid,
  input  logic [PC_W-1:0]   bp_addr,
  input  logic [PC_W-1:0]   core_pc,
  input  logic [DATA_W-1:0] core_result,
  output logic              core_en,
  output logic              core_rst_n,
  output logic [1:0]        state,
  output logic [2:0]        halt_cause,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [DATA_W-1:0] last_result,
  output logic              done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INIT = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam logic [2:0] C_NONE = 3'd0;
  localparam logic [2:0] C_STOP = 3'd1;
  localparam logic [2:0] C_BP   = 3'd2;
  localparam logic [2:0] C_LOOP = 3'd3;
  localparam logic [2:0] C_WD   = 3'd4;

  logic [1:0]      next_state;
  logic [2:0]      cause_c;
  logic [PC_W-1:0] prev_pc;
  logic            prev_en;
  logic            step_pend;
  logic            bp_hit_c;
  logic            loop_hit_c;
  logic            wd_hit_c;

`ifdef RUN_CTRL_BREAKPOINT_EN
  logic skip;
  // Skip flag lets the instruction at the breakpoint run once after launch/resume.
  assign bp_hit_c = bp_valid && (core_pc == bp_addr) && !skip;
`else
  logic unused_bp;
  assign unused_bp = ^{bp_valid, bp_addr};
  assign bp_hit_c  = 1'b0;
`endif

  assign loop_hit_c = prev_en && (core_pc == prev_pc);
  assign wd_hit_c   = (cycle_count == CNT_W'(MAX_CYCLES));

  // Next state, halt cause and combinational core controls
  always_comb begin
    next_state = state;
    cause_c    = C_NONE;
    core_en    = 1'b0;
    core_rst_n = 1'b1;
    case (state)
      S_IDLE: if (start) next_state = S_INIT;
      S_INIT: begin
        core_rst_n = 1'b0;
        next_state = S_RUN;
      end
      S_RUN: begin
        if (stop)            cause_c = C_STOP;
        else if (bp_hit_c)   cause_c = C_BP;
        else if (loop_hit_c) cause_c = C_LOOP;
        else if (wd_hit_c)   cause_c = C_WD;
        if (cause_c != C_NONE) next_state = S_HALT;
        else                   core_en    = 1'b1;
      end
      default: begin
        core_en = step_pend;
        if (start) next_state = S_RUN;
      end
    endcase
    if (!rst_n) begin
      core_en    = 1'b0;
      core_rst_n = 1'b0;
    end
  end

  // State, counters and captured results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      halt_cause  <= C_NONE;
      cycle_count <= '0;
      last_result <= '0;
      done        <= 1'b0;
      prev_pc     <= '0;
      prev_en     <= 1'b0;
      step_pend   <= 1'b0;
`ifdef RUN_CTRL_BREAKPOINT_EN
      skip        <= 1'b0;
`endif
    end else begin
      state     <= next_state;
      done      <= (state == S_RUN) && (next_state == S_HALT);
      prev_en   <= core_en;
      step_pend <= (state == S_HALT) && step && !start;
      if (core_en) begin
        if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
        last_result <= core_result;
        prev_pc     <= core_pc;
`ifdef RUN_CTRL_BREAKPOINT_EN
        skip        <= 1'b0;
`endif
      end
      // State-specific updates come last so a resume overrides the step cycle's skip clear.
      case (state)
        S_INIT: begin
          cycle_count <= '0;
          halt_cause  <= C_NONE;
`ifdef RUN_CTRL_BREAKPOINT_EN
          skip        <= 1'b1;
`endif
        end
        S_RUN: if (cause_c != C_NONE) halt_cause <= cause_c;
        S_HALT: if (start) begin
          halt_cause <= C_NONE;
`ifdef RUN_CTRL_BREAKPOINT_EN
          skip       <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_run_ctrl.sv
// Directed bench for datapath_run_ctrl with a small behavioural PC model standing in for the core.
module tb_datapath_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        step = 1'b0;
  logic        stop = 1'b0;
  logic        bp_valid = 1'b0;
  logic [7:0]  bp_addr = 8'd0;
  logic [7:0]  core_pc = 8'd0;
  logic [31:0] core_result;
  logic        core_en;
  logic        core_rst_n;
  logic [1:0]  state;
  logic [2:0]  halt_cause;
  logic [15:0] cycle_count;
  logic [31:0] last_result;
  logic        done;

  int total = 0;
  int bad = 0;
  int prog = 0;
  bit seen;

  datapath_run_ctrl #(.PC_W(8), .DATA_W(32), .CNT_W(16), .MAX_CYCLES(20)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step(step), .stop(stop),
    .bp_valid(bp_valid), .bp_addr(bp_addr), .core_pc(core_pc), .core_result(core_result),
    .core_en(core_en), .core_rst_n(core_rst_n), .state(state), .halt_cause(halt_cause),
    .cycle_count(cycle_count), .last_result(last_result), .done(done)
  );

  always #5 clk = ~clk;

  // prog 0: straight line 0..8 then branch-to-self at 12; prog 1: endless 0<->1 loop
  function automatic logic [7:0] nxt(input logic [7:0] pc);
    if (prog == 1) return (pc == 8'd0) ? 8'd1 : 8'd0;
    return (pc < 8'd8) ? pc + 8'd1 : 8'd12;
  endfunction

  always @(posedge clk)
    if (!core_rst_n) core_pc <= 8'd0;
    else if (core_en) core_pc <= nxt(core_pc);

  assign core_result = 32'hC0DE_0000 | 32'(core_pc);

  task automatic launch();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(output bit s);
    s = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin s = 1'b1; break; end
    end
  endtask

  task automatic wait_pc(input logic [7:0] pc, output bit s);
    s = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (state === 2'd2 && core_pc === pc) begin s = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if ({core_en, core_rst_n, done} !== 3'b000) begin bad++; $display("FAIL reset_ctl got=%b exp=000", {core_en, core_rst_n, done}); end
    total++; if ({halt_cause, cycle_count, last_result} !== 51'd0) begin bad++; $display("FAIL reset_regs cause=%0d cnt=%0d res=%0h exp=0", halt_cause, cycle_count, last_result); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    total++; if ({state, core_rst_n, core_en} !== 4'b0010) begin bad++; $display("FAIL idle_ctl got=%b exp=0010", {state, core_rst_n, core_en}); end
  endtask

  task automatic test_launch();
    prog = 0; bp_valid = 1'b0;
    launch();
    @(negedge clk);
    total++; if ({state, core_rst_n, core_en} !== 4'b0100) begin bad++; $display("FAIL init_ctl got=%b exp=0100", {state, core_rst_n, core_en}); end
    @(negedge clk);
    total++; if ({state, core_en, core_pc} !== {2'd2, 1'b1, 8'd0}) begin bad++; $display("FAIL run_first got st=%0d en=%b pc=%0d exp st=2 en=1 pc=0", state, core_en, core_pc); end
    wait_done(seen);
    total++; if (!seen) begin bad++; $display("FAIL launch_done got=timeout exp=done"); end
    total++; if (halt_cause !== 3'd3) begin bad++; $display("FAIL launch_cause got=%0d exp=3", halt_cause); end
    total++; if (cycle_count !== 16'd10) begin bad++; $display("FAIL launch_count got=%0d exp=10", cycle_count); end
    total++; if (last_result !== 32'hC0DE_000C) begin bad++; $display("FAIL launch_result got=%0h exp=c0de000c", last_result); end
    total++; if (core_pc !== 8'd12) begin bad++; $display("FAIL launch_pc got=%0d exp=12", core_pc); end
    @(negedge clk);
    total++; if ({done, core_en, state} !== 4'b0011) begin bad++; $display("FAIL launch_once got=%b exp=0011", {done, core_en, state}); end
  endtask

  task automatic test_stop_start();
    prog = 0; bp_valid = 1'b0;
    launch();
    wait_pc(8'd4, seen);
    total++; if (!seen) begin bad++; $display("FAIL stop_reach got=timeout exp=pc4"); end
    stop = 1'b1; start = 1'b1;
    #1;
    total++; if (core_en !== 1'b0) begin bad++; $display("FAIL stop_en got=%b exp=0", core_en); end
    @(posedge clk); #1 stop = 1'b0; start = 1'b0;
    @(negedge clk);
    total++; if ({state, done, halt_cause} !== {2'd3, 1'b1, 3'd1}) begin bad++; $display("FAIL stop_halt got st=%0d done=%b cause=%0d exp st=3 done=1 cause=1", state, done, halt_cause); end
    total++; if ({cycle_count, core_pc} !== {16'd4, 8'd4}) begin bad++; $display("FAIL stop_pos got cnt=%0d pc=%0d exp cnt=4 pc=4", cycle_count, core_pc); end
    @(negedge clk);
    total++; if ({state, done, core_en} !== 4'b1100) begin bad++; $display("FAIL stop_noresume got=%b exp=1100", {state, done, core_en}); end
  endtask

  task automatic test_step();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 step = 1'b1;
      @(negedge clk);
      total++; if (core_en !== 1'b0) begin bad++; $display("FAIL step_early%0d got=%b exp=0", i, core_en); end
      @(posedge clk); #1 step = 1'b0;
      @(negedge clk);
      total++; if ({core_en, core_pc} !== {1'b1, 8'(4 + i)}) begin bad++; $display("FAIL step_pulse%0d got en=%b pc=%0d exp en=1 pc=%0d", i, core_en, core_pc, 4 + i); end
      @(negedge clk);
      total++; if ({core_en, done, state} !== 4'b0011) begin bad++; $display("FAIL step_after%0d got=%b exp=0011", i, {core_en, done, state}); end
    end
    total++; if ({cycle_count, core_pc} !== {16'd7, 8'd7}) begin bad++; $display("FAIL step_count got cnt=%0d pc=%0d exp cnt=7 pc=7", cycle_count, core_pc); end
    total++; if ({halt_cause, last_result} !== {3'd1, 32'hC0DE_0006}) begin bad++; $display("FAIL step_keep got cause=%0d res=%0h exp cause=1 res=c0de0006", halt_cause, last_result); end
  endtask

  task automatic test_resume();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    total++; if ({state, halt_cause, core_en, core_pc} !== {2'd2, 3'd0, 1'b1, 8'd7}) begin bad++; $display("FAIL resume_run got st=%0d cause=%0d en=%b pc=%0d exp st=2 cause=0 en=1 pc=7", state, halt_cause, core_en, core_pc); end
    wait_done(seen);
    total++; if ({seen, halt_cause, cycle_count} !== {1'b1, 3'd3, 16'd10}) begin bad++; $display("FAIL resume_end got seen=%b cause=%0d cnt=%0d exp seen=1 cause=3 cnt=10", seen, halt_cause, cycle_count); end
  endtask

  task automatic test_breakpoint();
    prog = 0; bp_valid = 1'b1; bp_addr = 8'd4;
    launch();
    wait_done(seen);
`ifdef RUN_CTRL_BREAKPOINT_EN
    total++; if ({seen, halt_cause, cycle_count, core_pc} !== {1'b1, 3'd2, 16'd4, 8'd4}) begin bad++; $display("FAIL bp_halt got seen=%b cause=%0d cnt=%0d pc=%0d exp seen=1 cause=2 cnt=4 pc=4", seen, halt_cause, cycle_count, core_pc); end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    total++; if ({state, core_en} !== 3'b101) begin bad++; $display("FAIL bp_skip got=%b exp=101", {state, core_en}); end
    wait_done(seen);
    total++; if ({seen, halt_cause, cycle_count} !== {1'b1, 3'd3, 16'd10}) begin bad++; $display("FAIL bp_resume got seen=%b cause=%0d cnt=%0d exp seen=1 cause=3 cnt=10", seen, halt_cause, cycle_count); end
`else
    total++; if ({seen, halt_cause, cycle_count, core_pc} !== {1'b1, 3'd3, 16'd10, 8'd12}) begin bad++; $display("FAIL bp_ignored got seen=%b cause=%0d cnt=%0d pc=%0d exp seen=1 cause=3 cnt=10 pc=12", seen, halt_cause, cycle_count, core_pc); end
`endif
    bp_valid = 1'b0;
  endtask

  task automatic test_watchdog();
    prog = 1;
    launch();
    wait_done(seen);
    total++; if ({seen, halt_cause, cycle_count} !== {1'b1, 3'd4, 16'd20}) begin bad++; $display("FAIL wd_halt got seen=%b cause=%0d cnt=%0d exp seen=1 cause=4 cnt=20", seen, halt_cause, cycle_count); end
    total++; if (last_result !== 32'hC0DE_0001) begin bad++; $display("FAIL wd_result got=%0h exp=c0de0001", last_result); end
    prog = 0;
  endtask

  task automatic test_reset_mid();
    prog = 0;
    launch();
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cycle_count === 16'd7) begin seen = 1'b1; break; end
    end
    total++; if (!seen) begin bad++; $display("FAIL rmid_reach got=timeout exp=cnt7"); end
    rst_n = 1'b0;
    #1;
    total++; if ({core_en, core_rst_n} !== 2'b00) begin bad++; $display("FAIL rmid_comb got=%b exp=00", {core_en, core_rst_n}); end
    @(posedge clk); #1;
    total++; if ({state, done, core_en} !== 4'b0000) begin bad++; $display("FAIL rmid_ctl got=%b exp=0000", {state, done, core_en}); end
    total++; if ({cycle_count, last_result} !== 48'd0) begin bad++; $display("FAIL rmid_regs got cnt=%0d res=%0h exp=0", cycle_count, last_result); end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_launch();
    test_stop_start();
    test_step();
    test_resume();
    test_breakpoint();
    test_watchdog();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/datapath_run_ctrl.md
# datapath_run_ctrl

Run/stop sequencer for the single-cycle `datapath` core: the core's program counter and result bus feed this block, and it drives the core's clock enable and reset. It gives a bench or debug host start, stop, single-step and PC-breakpoint control. It also detects program end (branch-to-self), enforces a cycle watchdog, and reports why the core halted. It sits between the top-level harness and `datapath`.

## Interface
- `PC_W`, 8, program-counter width (matches `datapath` pc)
- `DATA_W`, 32, result width
- `CNT_W`, 16, cycle-counter width
- `MAX_CYCLES`, 1000, watchdog limit on enabled cycles

- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  pulse: launch program from IDLE, or resume from HALT
- `step`  in  1  pulse: execute exactly one instruction while in HALT
- `stop`  in  1  pulse: halt a running program
- `bp_valid`  in  1  breakpoint armed (gated by `RUN_CTRL_BREAKPOINT_EN`)
- `bp_addr`  in  PC_W  breakpoint PC
- `core_pc`  in  PC_W  current PC from datapath
- `core_result`  in  DATA_W  result bus from datapath
- `core_en`  out  1  datapath clock enable; the core advances only on edges where this is 1
- `core_rst_n`  out  1  datapath synchronous reset, active low
- `state`  out  2  0 IDLE, 1 INIT, 2 RUN, 3 HALT
- `halt_cause`  out  3  0 none, 1 stop, 2 breakpoint, 3 self-loop, 4 watchdog
- `cycle_count`  out  CNT_W  number of enabled cycles since launch
- `last_result`  out  DATA_W  `core_result` sampled on the last enabled cycle
- `done`  out  1  one-cycle pulse on entry to HALT

## Operation
- Reset values (while `rst_n`=0):
  - state IDLE
  - `core_en`=0, `core_rst_n`=0
  - `halt_cause`=0, `cycle_count`=0, `last_result`=0, `done`=0
  - skip flag cleared
- IDLE:
  - `core_rst_n`=1, `core_en`=0.
  - `start` -> INIT.
  - `step` and `stop` are ignored.
- INIT:
  - Lasts exactly one cycle, with `core_rst_n`=0 and `core_en`=0.
  - Clears `cycle_count` and `halt_cause`, sets the skip flag, then -> RUN.
- RUN:
  - `core_en` = 1 unless a halt condition holds this cycle; it is combinational from state and conditions.
  - Halt conditions, in priority order (highest first):
    - `stop` -> cause 1.
    - Breakpoint: `bp_valid` && `core_pc`==`bp_addr` && skip flag clear -> cause 2. The instruction at `bp_addr` is NOT executed.
    - Self-loop: the previous cycle was enabled and `core_pc` equals the PC sampled on that cycle -> cause 3.
    - Watchdog: `cycle_count`==`MAX_CYCLES` -> cause 4.
  - Any halt condition: `core_en`=0 this cycle, state -> HALT, `done` pulses next cycle.
- Every enabled cycle:
  - `cycle_count` increments, saturating at all-ones.
  - `last_result` <= `core_result`.
  - prev-PC register <= `core_pc`.
  - Skip flag clears.
- HALT:
  - `core_en`=0.
  - `start` -> RUN (resume, no core reset): sets skip flag, sets `halt_cause` to 0.
  - `step`: on the next cycle `core_en`=1 for exactly one cycle, breakpoint check skipped; state stays HALT and `halt_cause` is kept.
  - `stop` is ignored.
- Simultaneous inputs:
  - `start` and `stop` in RUN: stop wins.
  - `start` and `step` in HALT: start wins, step dropped.
  - Any input in INIT: ignored.
- Reset mid-operation: synchronous `rst_n`=0 overrides everything on that edge. `core_en` falls combinationally and all registers return to reset values.

## Timing
- `start` sampled in IDLE at edge N:
  - INIT during cycle N+1.
  - RUN from N+2; first `core_en`=1 in cycle N+2.
- `stop` asserted in RUN cycle M: `core_en`=0 in cycle M (combinational); state HALT and `done`=1 in M+1.
- Breakpoint: `core_en` drops in the same cycle `core_pc` matches; `core_pc` remains `bp_addr` in HALT.
- `step` sampled in HALT at edge K: `core_en`=1 in cycle K+1 only; `cycle_count` +1.
- Self-loop latency: HALT one cycle after the PC repeats, so the loop instruction executes exactly once.
- `cycle_count` and `last_result` update on the edge that ends an enabled cycle.

## Configuration
- `RUN_CTRL_BREAKPOINT_EN` defined: breakpoint logic, skip flag and `bp_*` ports are active as described.
- Not defined:
  - `bp_valid` and `bp_addr` remain as ports but are ignored.
  - No comparator is synthesized.
  - Cause 2 is never reported.
  - The skip flag is removed.

## Test plan
- Launch: reset, then `start`; program loops at PC 12 after 9 instructions -> INIT for 1 cycle with `core_rst_n`=0, RUN, HALT with `halt_cause`=3, `cycle_count`=10, `done` pulses once.
- Breakpoint (macro defined): `bp_valid`=1, `bp_addr`=4 -> halt with `core_pc`=4, cause 2, `cycle_count`=4. `start` -> resumes past PC 4 without re-halting.
- Step: halted at PC 4, three `step` pulses spaced 3 cycles apart -> three single `core_en` pulses, `cycle_count` +3, state HALT, `done` not re-pulsed.
- Stop vs start: in RUN, assert `stop` and `start` together -> `core_en`=0 in the same cycle, cause 1, no resume.
- Watchdog: `MAX_CYCLES`=20 with a non-terminating two-instruction loop -> HALT cause 4 with `cycle_count`=20.
- Reset mid-run: `rst_n`=0 during RUN at cycle 7 -> next edge: state IDLE, `core_en`=0, `cycle_count`=0, `last_result`=0.
